// File: rtl/sirv_gnrl_skid_buf.sv
// sirv_gnrl_skid_buf: two-entry registered valid/ready skid buffer (main + skid entry).
// Optional synchronous flush port enabled by defining SIRV_GNRL_SKID_FLUSH_EN.
module sirv_gnrl_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SIRV_GNRL_SKID_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);
    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] main_dat_q, main_dat_d;
    logic [DW-1:0] skid_dat_q, skid_dat_d;
    logic          ihs, ohs, kill;

    assign i_rdy = ~skid_vld_q;
    assign o_vld = main_vld_q;
    assign o_dat = main_dat_q;
    assign ihs   = i_vld & i_rdy;
    assign ohs   = o_vld & o_rdy;
`ifdef SIRV_GNRL_SKID_FLUSH_EN
    assign kill  = flush;
`else
    assign kill  = 1'b0;
`endif

    // Occupancy only moves EMPTY<->ONE<->FULL, so skid_vld implies main_vld.
    always_comb begin
        main_vld_d = ~kill & (skid_vld_q | ihs | (main_vld_q & ~o_rdy));
        skid_vld_d = ~kill & (skid_vld_q ? ~ohs : (main_vld_q & ihs & ~o_rdy));
        main_dat_d = skid_vld_q ? (ohs ? skid_dat_q : main_dat_q)
                   : (ihs & (~main_vld_q | o_rdy)) ? i_dat : main_dat_q;
        skid_dat_d = (~skid_vld_q & main_vld_q & ihs & ~o_rdy) ? i_dat : skid_dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end
endmodule
